result_writer: RTL and testbench
================================

RESULT_WRITER -- requirements
Module: result_writer

Interface
REQ-001 SHALL provide parameter NPAIRS, default 5, meaning the number of operand pairs processed per run (legal range 1..8).
REQ-002 SHALL provide parameter SETTLE, default 8, meaning the clock cycles allowed for the ripple adder output to settle after an address change (legal range 1..15).
REQ-003 SHALL provide port clk  input  1  rising-edge clock.
REQ-004 SHALL provide port rst_n  input  1  reset; asynchronous, active-low.
REQ-005 SHALL provide port start  input  1  run request, sampled on clk.
REQ-006 SHALL provide port abort  input  1  synchronous run cancel.
REQ-007 SHALL provide port sum  input  32  adder result for the current address.
REQ-008 SHALL provide port carry  input  1  adder carry-out for the current address.
REQ-009 SHALL provide port addr  output  6  registered operand-pair address to the adder, always 2*idx.
REQ-010 SHALL provide port busy  output  1  high while a run is in progress.
REQ-011 SHALL provide port done  output  1  one-cycle pulse at run completion.
REQ-012 SHALL provide port wr_en  output  1  one-cycle write strobe into the result store.
REQ-013 SHALL provide port wr_addr  output  3  result-store index being written.
REQ-014 SHALL provide port wr_data  output  33  {carry, sum} being written.
REQ-015 SHALL provide port rd_addr  input  3  result-store read index.
REQ-016 SHALL provide port rd_data  output  33  combinational read of the result-store entry selected by rd_addr.
REQ-017 SHALL provide port count  output  4  entries written in the current or last run.
REQ-018 SHALL provide port carry_cnt  output  4  written entries with carry=1 in the current or last run.

Function
REQ-019 SHALL implement the states IDLE, ISSUE, SETTLE, WRITE and DONE.
REQ-020 In IDLE, start=1 SHALL clear idx, count and carry_cnt and move to ISSUE, with busy=1 from the next cycle.
REQ-021 ISSUE SHALL last exactly one cycle, drive addr=2*idx, load the settle counter with SETTLE-1, and move to SETTLE.
REQ-022 SETTLE SHALL decrement the settle counter each cycle and move to WRITE in the cycle after the counter reads 0, so it lasts exactly SETTLE cycles.
REQ-023 WRITE SHALL last one cycle, assert wr_en with wr_addr=idx and wr_data={carry,sum} sampled that cycle, store that value in entry idx, and increment count.
REQ-024 WRITE SHALL also increment carry_cnt when carry=1.
REQ-025 After WRITE, the block SHALL increment idx and go to ISSUE if idx<NPAIRS-1, else go to DONE.
REQ-026 DONE SHALL last one cycle with done=1 and busy=0, then return to IDLE.
REQ-027 Per-pair latency SHALL be SETTLE+2 cycles, and the start-accept edge to done pulse SHALL be NPAIRS*(SETTLE+2)+1 cycles.
REQ-028 A start pulse while busy, or in the DONE cycle, SHALL be ignored.
REQ-029 addr SHALL hold its value through SETTLE and WRITE.
REQ-030 abort=1 in any non-IDLE state SHALL return the block to IDLE on the next edge with no wr_en that cycle and no done pulse.
REQ-031 After an abort, count, carry_cnt and the entries already written SHALL be retained.
REQ-032 abort and start asserted together in IDLE SHALL mean abort wins, and no run starts.
REQ-033 The result store SHALL be 8 x 33 bits, entries at or above NPAIRS SHALL never be written, and a new run SHALL overwrite entries without clearing them first.
REQ-034 rd_data SHALL reflect a write in the same cycle as the clock edge of that write, i.e. no bypass, and show the new value after the edge.
REQ-035 count and carry_cnt SHALL not wrap, since their maximum is 8.

Reset
REQ-036 rst_n=0 SHALL immediately force the state to IDLE, and set idx, addr, count, carry_cnt, busy, done, wr_en, wr_addr and wr_data to 0.
REQ-037 rst_n=0 SHALL clear all result-store entries to 0.
REQ-038 Reset asserted mid-run SHALL abandon the run, with no done pulse.
REQ-039 After rst_n deasserts, the first start SHALL be accepted on the first rising edge at which rst_n is high.

Verification
REQ-040 Default parameters, bench adder model sums 1+2, 0xFFFFFFFF+1, 5+5, 0x80000000+0x80000000, 0+0; pulse start -> addr sequence 0,2,4,6,8; wr_data 0x000000003, 0x100000000, 0x00000000A, 0x100000000, 0x000000000; count=5, carry_cnt=2; done exactly 51 cycles after start accepted.
REQ-041 start re-pulsed every cycle during a run -> exactly one done pulse and 5 wr_en pulses.
REQ-042 abort in the cycle of the third WRITE -> no third wr_en, count=2, busy=0 on the next cycle, no done pulse, entries 0..1 readable via rd_data.
REQ-043 rst_n pulled low during SETTLE of pair 1 -> all outputs 0 asynchronously, rd_data=0 for all rd_addr, and a later start completes a full run normally.
REQ-044 NPAIRS=1, SETTLE=1 -> single wr_en 2 cycles after ISSUE, done 4 cycles after start accepted, and entries 1..7 unchanged.
REQ-045 sum changed by the bench during SETTLE and stable at WRITE -> the stored value equals the value present in the WRITE cycle.

Source files
------------

// File: rtl/result_writer.sv
// Sequences operand-pair addresses to a slow ripple adder, waits for it to settle,
// and captures {carry, sum} for each pair into an 8-entry result store.
module result_writer #(
    parameter int NPAIRS = 5,
    parameter int SETTLE = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        abort,
    input  logic [31:0] sum,
    input  logic        carry,
    output logic [5:0]  addr,
    output logic        busy,
    output logic        done,
    output logic        wr_en,
    output logic [2:0]  wr_addr,
    output logic [32:0] wr_data,
    input  logic [2:0]  rd_addr,
    output logic [32:0] rd_data,
    output logic [3:0]  count,
    output logic [3:0]  carry_cnt
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_SETTLE,
        S_WRITE,
        S_DONE
    } state_t;

    localparam logic [2:0] LAST_IDX    = 3'(NPAIRS - 1);
    localparam logic [3:0] SETTLE_INIT = 4'(SETTLE - 1);

    state_t      state_q;
    logic [2:0]  idx_q;
    logic [3:0]  settle_q;
    logic [5:0]  addr_q;
    logic        busy_q;
    logic        done_q;
    logic        wr_en_q;
    logic [2:0]  wr_addr_q;
    logic [3:0]  count_q;
    logic [3:0]  carry_cnt_q;
    logic [32:0] mem_q [8];
    logic [32:0] wr_data_d;

    assign wr_data_d = {carry, sum};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            settle_q    <= '0;
            addr_q      <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            count_q     <= '0;
            carry_cnt_q <= '0;
            for (int i = 0; i < 8; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_en_q <= 1'b0;
            done_q  <= 1'b0;
            // Cancel drops straight to IDLE; counters and stored entries are kept.
            if (state_q != S_IDLE && abort) begin
                state_q <= S_IDLE;
                busy_q  <= 1'b0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (start) begin
                            idx_q       <= '0;
                            addr_q      <= '0;
                            count_q     <= '0;
                            carry_cnt_q <= '0;
                            busy_q      <= 1'b1;
                            state_q     <= S_ISSUE;
                        end
                    end
                    S_ISSUE: begin
                        settle_q <= SETTLE_INIT;
                        state_q  <= S_SETTLE;
                    end
                    S_SETTLE: begin
                        if (settle_q == 4'd0) begin
                            wr_en_q   <= 1'b1;
                            wr_addr_q <= idx_q;
                            state_q   <= S_WRITE;
                        end else begin
                            settle_q <= settle_q - 4'd1;
                        end
                    end
                    S_WRITE: begin
                        mem_q[idx_q] <= wr_data_d;
                        count_q      <= count_q + 4'd1;
                        if (carry) begin
                            carry_cnt_q <= carry_cnt_q + 4'd1;
                        end
                        if (idx_q < LAST_IDX) begin
                            idx_q   <= idx_q + 3'd1;
                            addr_q  <= {2'b00, idx_q + 3'd1, 1'b0};
                            state_q <= S_ISSUE;
                        end else begin
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= S_DONE;
                        end
                    end
                    S_DONE: begin
                        state_q <= S_IDLE;
                    end
                    default: begin
                        state_q <= S_IDLE;
                    end
                endcase
            end
        end
    end

    // Strobes are masked by a same-cycle abort so a cancelled WRITE/DONE is invisible.
    assign wr_en     = wr_en_q & ~abort;
    assign done      = done_q & ~abort;
    assign wr_data   = wr_en ? wr_data_d : '0;
    assign wr_addr   = wr_addr_q;
    assign addr      = addr_q;
    assign busy      = busy_q;
    assign count     = count_q;
    assign carry_cnt = carry_cnt_q;
    assign rd_data   = mem_q[rd_addr];

endmodule

// File: tb/tb_result_writer.sv
// Bench for result_writer: cycle-offset reference model plus directed runs
// (normal, start spam, abort, mid-run reset, changing sum, minimal parameters).
`timescale 1ns/1ps
module tb_result_writer;

    localparam int N = 5;
    localparam int S = 8;
    localparam int T = N * (S + 2);

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [2:0]  rd_addr = '0;
    logic [31:0] sum;
    logic        carry;
    logic [5:0]  addr;
    logic        busy, done, wr_en;
    logic [2:0]  wr_addr;
    logic [32:0] wr_data, rd_data;
    logic [3:0]  count, carry_cnt;

    logic        start2 = 1'b0;
    logic [2:0]  rd_addr2 = '0;
    logic [5:0]  addr2;
    logic        busy2, done2, wr_en2;
    logic [2:0]  wr_addr2;
    logic [32:0] wr_data2, rd_data2;
    logic [3:0]  count2, carry_cnt2;

    always #5 clk = ~clk;

    result_writer #(.NPAIRS(N), .SETTLE(S)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .sum(sum), .carry(carry), .addr(addr), .busy(busy), .done(done),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr(rd_addr), .rd_data(rd_data), .count(count), .carry_cnt(carry_cnt)
    );

    result_writer #(.NPAIRS(1), .SETTLE(1)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .abort(1'b0),
        .sum(32'h12345678), .carry(1'b1), .addr(addr2), .busy(busy2), .done(done2),
        .wr_en(wr_en2), .wr_addr(wr_addr2), .wr_data(wr_data2),
        .rd_addr(rd_addr2), .rd_data(rd_data2), .count(count2), .carry_cnt(carry_cnt2)
    );

    // Adder model: operand pair addr/2, optionally overridden by the bench.
    logic [31:0] op_a [8] = '{32'd1, 32'hFFFFFFFF, 32'd5, 32'h80000000, 32'd0, 32'd0, 32'd0, 32'd0};
    logic [31:0] op_b [8] = '{32'd2, 32'd1, 32'd5, 32'h80000000, 32'd0, 32'd0, 32'd0, 32'd0};
    logic        ovr_en = 1'b0;
    logic [31:0] ovr_sum = '0;
    logic        ovr_c = 1'b0;
    logic [32:0] add_full;

    always_comb begin
        add_full = '0;
        if (addr < 6'd10) add_full = {1'b0, op_a[addr[3:1]]} + {1'b0, op_b[addr[3:1]]};
        if (ovr_en) add_full = {ovr_c, ovr_sum};
    end
    assign sum   = add_full[31:0];
    assign carry = add_full[32];

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: mt is the cycle number within a run (0 = idle).
    int          mt = 0;
    logic [3:0]  mcount = '0;
    logic [3:0]  mcc = '0;
    logic [32:0] mmem [8];

    initial for (int i = 0; i < 8; i++) mmem[i] = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mt = 0; mcount = '0; mcc = '0;
            for (int i = 0; i < 8; i++) mmem[i] = '0;
        end else if (mt == 0) begin
            if (start && !abort) begin mt = 1; mcount = '0; mcc = '0; end
        end else if (abort) begin
            mt = 0;
        end else begin
            if (mt <= T && (mt - 1) % (S + 2) == S + 1) begin
                mmem[(mt - 1) / (S + 2)] = {carry, sum};
                mcount = mcount + 4'd1;
                if (carry) mcc = mcc + 4'd1;
            end
            mt = (mt == T + 1) ? 0 : mt + 1;
        end
    end

    int pos_e, pair_e;
    bit b_e, w_e, d_e;

    always @(negedge clk) begin
        #1;
        if (rst_n) begin
            b_e    = (mt >= 1 && mt <= T);
            pos_e  = (mt >= 1) ? (mt - 1) % (S + 2) : 0;
            pair_e = (mt >= 1) ? (mt - 1) / (S + 2) : 0;
            w_e    = b_e && pos_e == S + 1 && !abort;
            d_e    = (mt == T + 1) && !abort;
            check("busy", 64'(busy), 64'(b_e));
            check("done", 64'(done), 64'(d_e));
            check("wr_en", 64'(wr_en), 64'(w_e));
            check("count", 64'(count), 64'(mcount));
            check("carry_cnt", 64'(carry_cnt), 64'(mcc));
            check("rd_data", 64'(rd_data), 64'(mmem[rd_addr]));
            if (b_e) check("addr", 64'(addr), 64'(2 * pair_e));
            if (w_e) begin
                check("wr_addr", 64'(wr_addr), 64'(pair_e));
                check("wr_data", 64'(wr_data), 64'({carry, sum}));
            end
        end
    end

    int          done_k, nwr, ndone;
    logic        busy_after;
    logic [32:0] wq [$];
    logic [5:0]  aq [$];

    // Called just after a negedge with the DUT idle; start is accepted at the next edge.
    task automatic run(input int abort_at, input bit hold, input bit ovr);
        wq.delete(); aq.delete();
        done_k = -1; nwr = 0; ndone = 0; busy_after = 1'bx;
        start = 1'b1;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            start   = hold && (k <= 50);
            abort   = (k == abort_at);
            ovr_en  = ovr && k >= 2 && k <= 10;
            ovr_sum = (k < 5) ? 32'h11111111 : 32'h22222222;
            ovr_c   = 1'b1;
            #2;
            if (wr_en) begin nwr++; wq.push_back(wr_data); aq.push_back(addr); end
            if (done) begin ndone++; if (done_k < 0) done_k = k; end
            if (k == abort_at + 1) busy_after = busy;
        end
        abort = 1'b0; ovr_en = 1'b0;
    endtask

    task automatic sweep_zero(input string nm);
        for (int i = 0; i < 8; i++) begin
            rd_addr = 3'(i); #0.1;
            check(nm, 64'(rd_data), 64'd0);
        end
    endtask

    logic [32:0] exp_wd [5] = '{33'h000000003, 33'h100000000, 33'h00000000A, 33'h100000000, 33'h000000000};
    int wk2, dk2;

    initial begin
        repeat (2) @(negedge clk);
        #2;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_wr_en", 64'(wr_en), 64'd0);
        check("rst_addr", 64'(addr), 64'd0);
        check("rst_wr_addr", 64'(wr_addr), 64'd0);
        check("rst_wr_data", 64'(wr_data), 64'd0);
        check("rst_count", 64'(count), 64'd0);
        check("rst_carry_cnt", 64'(carry_cnt), 64'd0);
        sweep_zero("rst_rd_data");

        // Normal run, start on the first edge after reset release
        @(negedge clk); rst_n = 1'b1; #2;
        run(0, 1'b0, 1'b0);
        check("A_done_cycle", 64'(done_k), 64'd51);
        check("A_nwr", 64'(nwr), 64'd5);
        for (int i = 0; i < 5; i++) begin
            check("A_wr_data", (i < wq.size()) ? 64'(wq[i]) : 64'hDEAD, 64'(exp_wd[i]));
            check("A_addr_seq", (i < aq.size()) ? 64'(aq[i]) : 64'hDEAD, 64'(2 * i));
        end
        check("A_count", 64'(count), 64'd5);
        check("A_carry_cnt", 64'(carry_cnt), 64'd2);
        for (int i = 0; i < 5; i++) begin
            rd_addr = 3'(i); #0.2;
            check("A_rd_data", 64'(rd_data), 64'(exp_wd[i]));
        end

        // Start held during the whole run
        @(negedge clk); #2;
        run(0, 1'b1, 1'b0);
        check("B_ndone", 64'(ndone), 64'd1);
        check("B_nwr", 64'(nwr), 64'd5);
        check("B_done_cycle", 64'(done_k), 64'd51);

        // Abort during the third WRITE
        @(negedge clk); #2;
        run(30, 1'b0, 1'b0);
        check("C_nwr", 64'(nwr), 64'd2);
        check("C_ndone", 64'(ndone), 64'd0);
        check("C_busy_after", 64'(busy_after), 64'd0);
        check("C_count", 64'(count), 64'd2);
        check("C_carry_cnt", 64'(carry_cnt), 64'd1);
        rd_addr = 3'd0; #0.2; check("C_rd0", 64'(rd_data), 64'h000000003);
        rd_addr = 3'd1; #0.2; check("C_rd1", 64'(rd_data), 64'h100000000);

        // Reset during SETTLE of pair 1
        @(negedge clk); #2;
        start = 1'b1;
        for (int k = 1; k <= 14; k++) begin
            @(negedge clk);
            start = 1'b0;
        end
        #3; rst_n = 1'b0; #1;
        check("D_busy", 64'(busy), 64'd0);
        check("D_addr", 64'(addr), 64'd0);
        check("D_count", 64'(count), 64'd0);
        check("D_carry_cnt", 64'(carry_cnt), 64'd0);
        check("D_wr_en", 64'(wr_en), 64'd0);
        check("D_done", 64'(done), 64'd0);
        sweep_zero("D_rd_data");
        @(negedge clk); rst_n = 1'b1; #2;
        run(0, 1'b0, 1'b0);
        check("D_done_cycle", 64'(done_k), 64'd51);
        check("D_count_after", 64'(count), 64'd5);
        check("D_carry_cnt_after", 64'(carry_cnt), 64'd2);

        // sum changes during SETTLE, final value held through WRITE
        @(negedge clk); #2;
        run(0, 1'b0, 1'b1);
        check("E_wr_data0", (wq.size() > 0) ? 64'(wq[0]) : 64'hDEAD, 64'h122222222);
        rd_addr = 3'd0; #0.2; check("E_rd0", 64'(rd_data), 64'h122222222);

        // Minimal configuration instance
        @(negedge clk); #2;
        wk2 = -1; dk2 = -1;
        start2 = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            start2 = 1'b0;
            #2;
            if (wr_en2 && wk2 < 0) wk2 = k;
            if (done2 && dk2 < 0) dk2 = k;
        end
        check("F_wr_cycle", 64'(wk2), 64'd3);
        check("F_done_cycle", 64'(dk2), 64'd4);
        check("F_count", 64'(count2), 64'd1);
        check("F_carry_cnt", 64'(carry_cnt2), 64'd1);
        for (int i = 0; i < 8; i++) begin
            rd_addr2 = 3'(i); #0.2;
            check("F_rd_data", 64'(rd_data2), (i == 0) ? 64'h112345678 : 64'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, required finish before 100000ns");
        $fatal(1, "watchdog");
    end

endmodule
